// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback side bundle for the register file and busy scoreboard.
// master = issue/writeback logic, slave = regfile_scoreboard.
interface regfile_scoreboard_if #(
   parameter int AW  = 5,
   parameter int DW  = 32,
   parameter int NRD = 2,
   parameter int NWR = 1
);
   logic [NWR-1:0]    wr_en;
   logic [NWR*AW-1:0] wr_addr;
   logic [NWR*DW-1:0] wr_data;
   logic [NRD*AW-1:0] rd_addr;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [AW:0]       busy_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      output rd_data, rd_busy, busy_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with x0 hardwired and a busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through to the read ports.
module regfile_scoreboard #(
   parameter int AW  = 5,
   parameter int DW  = 32,
   parameter int NRD = 2,
   parameter int NWR = 1
) (
   input logic                clk,
   input logic                rst,
   regfile_scoreboard_if.slave bus
);
   localparam int NREG = 2 ** AW;
   localparam logic [AW:0] ONE = (AW+1)'(1);

   logic [DW-1:0]     regs [1:NREG-1];
   logic [NREG-1:1]   busy;
   logic [NREG-1:1]   set_v;
   logic [NREG-1:1]   clr_v;
   logic [NREG-1:1]   busy_nxt;
   logic [AW:0]       busy_cnt;
   logic [AW:0]       n_set;
   logic [AW:0]       n_clr;
   logic [AW:0]       cnt_nxt;
   logic [NRD*DW-1:0] rd_data;
   logic [NRD-1:0]    rd_busy;

   always_comb begin
      set_v = '0;
      clr_v = '0;
      for (int k = 1; k < NREG; k++) begin
         set_v[k] = bus.iss_en && (bus.iss_addr == AW'(k));
         for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] == AW'(k)))
               clr_v[k] = 1'b1;
         end
      end
   end

   // A reservation supersedes a completing write to the same register.
   assign busy_nxt = set_v | (busy & ~clr_v);

   always_comb begin
      n_set = '0;
      n_clr = '0;
      for (int k = 1; k < NREG; k++) begin
         if (set_v[k] && !busy[k])
            n_set = n_set + ONE;
         if (clr_v[k] && busy[k] && !set_v[k])
            n_clr = n_clr + ONE;
      end
   end

   assign cnt_nxt = busy_cnt + n_set - n_clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k < NREG; k++)
            regs[k] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         // Ascending port order lets the highest port win a collision.
         for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p*AW +: AW] != '0))
               regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*DW +: DW];
         end
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          b;

      assign a = bus.rd_addr[r*AW +: AW];

      always_comb begin
         d = '0;
         b = 1'b0;
         if (a != '0) begin
            d = regs[a];
            b = busy[a];
         end
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWR; p++) begin
            if (bus.wr_en[p] && (a != '0) &&
                (bus.wr_addr[p*AW +: AW] == a)) begin
               d = bus.wr_data[p*DW +: DW];
               b = bus.iss_en && (bus.iss_addr == a);
            end
         end
`endif
      end

      assign rd_data[r*DW +: DW] = d;
      assign rd_busy[r]          = b;
   end

   assign bus.rd_data  = rd_data;
   assign bus.rd_busy  = rd_busy;
   assign bus.busy_cnt = busy_cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, x0, scoreboard, bypass,
// and dual-port collision, with hand-computed expectations.
module tb_regfile_scoreboard;
   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int NRD = 2;
   localparam int NWR = 2;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   regfile_scoreboard_if #(.AW(AW), .DW(DW), .NRD(NRD), .NWR(NWR)) bus ();

   regfile_scoreboard #(.AW(AW), .DW(DW), .NRD(NRD), .NWR(NWR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.wr_en    = '0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.iss_en   = 1'b0;
      bus.iss_addr = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      idle();
      bus.rd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset_cnt", 64'(bus.busy_cnt), 64'd0);
      chk("reset_data", 64'(bus.rd_data), 64'd0);

      // x5 written and x6 reserved, then reset mid-stream
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd5};
      bus.wr_data  = {32'd0, 32'hDEADBEEF};
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd6;
      tick();
      bus.rd_addr = {5'd6, 5'd5};
      #1;
      chk("x5_written", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
      chk("x6_busy", 64'(bus.rd_busy[1]), 64'd1);
      chk("cnt_one", 64'(bus.busy_cnt), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_data", 64'(bus.rd_data), 64'd0);
      chk("async_rst_busy", 64'(bus.rd_busy), 64'd0);
      chk("async_rst_cnt", 64'(bus.busy_cnt), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // x0 hardwire
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd0};
      bus.wr_data  = {32'd0, 32'h12345678};
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd0;
      tick();
      bus.rd_addr = {5'd0, 5'd0};
      #1;
      chk("x0_data", 64'(bus.rd_data[31:0]), 64'd0);
      chk("x0_busy", 64'(bus.rd_busy[0]), 64'd0);
      chk("x0_cnt", 64'(bus.busy_cnt), 64'd0);

      // scoreboard round trip on x7
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd7;
      tick();
      bus.rd_addr = {5'd0, 5'd7};
      #1;
      chk("x7_busy", 64'(bus.rd_busy[0]), 64'd1);
      chk("x7_cnt", 64'(bus.busy_cnt), 64'd1);
      tick();
      bus.wr_en   = 2'b01;
      bus.wr_addr = {5'd0, 5'd7};
      bus.wr_data = {32'd0, 32'hA5A5A5A5};
      tick();
      #1;
      chk("x7_data", 64'(bus.rd_data[31:0]), 64'hA5A5A5A5);
      chk("x7_clr", 64'(bus.rd_busy[0]), 64'd0);
      chk("x7_cnt0", 64'(bus.busy_cnt), 64'd0);

      // issue and write x3 in the same cycle
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd3;
      tick();
      bus.wr_en    = 2'b01;
      bus.wr_addr  = {5'd0, 5'd3};
      bus.wr_data  = {32'd0, 32'h11};
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd3;
      tick();
      bus.rd_addr = {5'd0, 5'd3};
      #1;
      chk("x3_data", 64'(bus.rd_data[31:0]), 64'h11);
      chk("x3_busy", 64'(bus.rd_busy[0]), 64'd1);
      chk("x3_cnt", 64'(bus.busy_cnt), 64'd1);

      // re-issue to an already busy register
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd3;
      tick();
      #1;
      chk("reissue_cnt", 64'(bus.busy_cnt), 64'd1);

      // same-cycle read of a write to x9
      bus.rd_addr = {5'd0, 5'd9};
      bus.wr_en   = 2'b01;
      bus.wr_addr = {5'd0, 5'd9};
      bus.wr_data = {32'd0, 32'hCAFEF00D};
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same", 64'(bus.rd_data[31:0]), 64'hCAFEF00D);
`else
      chk("byp_same", 64'(bus.rd_data[31:0]), 64'd0);
`endif
      chk("byp_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();
      #1;
      chk("byp_next", 64'(bus.rd_data[31:0]), 64'hCAFEF00D);

      // dual-write collision on x4, x3 still busy
      bus.iss_en   = 1'b1;
      bus.iss_addr = 5'd4;
      tick();
      #1;
      chk("x4_cnt2", 64'(bus.busy_cnt), 64'd2);
      bus.wr_en   = 2'b11;
      bus.wr_addr = {5'd4, 5'd4};
      bus.wr_data = {32'h2, 32'h1};
      tick();
      bus.rd_addr = {5'd3, 5'd4};
      #1;
      chk("coll_data", 64'(bus.rd_data[31:0]), 64'h2);
      chk("coll_busy", 64'(bus.rd_busy), 64'b10);
      chk("coll_cnt", 64'(bus.busy_cnt), 64'd1);

      // port 1 retires x3 and writes top register x31 via port 0
      bus.wr_en   = 2'b11;
      bus.wr_addr = {5'd3, 5'd31};
      bus.wr_data = {32'h33, 32'h7FFF0001};
      tick();
      bus.rd_addr = {5'd31, 5'd3};
      #1;
      chk("p1_x3", 64'(bus.rd_data[31:0]), 64'h33);
      chk("x31", 64'(bus.rd_data[63:32]), 64'h7FFF0001);
      chk("final_cnt", 64'(bus.busy_cnt), 64'd0);
      chk("final_busy", 64'(bus.rd_busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
